vga_timing_gen: RTL and testbench

- Parametrised successor to the fixed 640x480 VGA counter.
- Generates pixel enable, column/row coordinates, sync and blank, plus copies of sync/blank delayed to match frame-buffer read latency.
- Also provides line/frame strobes, a frame counter, a run enable and a synchronous restart.
- Sits between clk_50 and the pixel-colour mux; feeds frame-buffer addressing and overlay drawers.

---
 rtl/vga_timing_gen.sv | 136 +++++++++++++
 tb/tb_vga_timing_gen.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing: pixel enable, coordinates, sync/blank decodes,
// latency-matched sync/blank copies, line/frame strobes and a frame counter.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CLK_DIV  = 2,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned PIPE     = 2,
  parameter int unsigned CW       = 10
) (
  input  logic          clk_50,
  input  logic          reset,
  input  logic          en,
  input  logic          sync_clr,
  output logic          pix_en,
  output logic [CW-1:0] col,
  output logic [CW-1:0] row,
  output logic          HS,
  output logic          VS,
  output logic          blank,
  output logic          HS_d,
  output logic          VS_d,
  output logic          blank_d,
  output logic          line_end,
  output logic          frame_end,
  output logic [7:0]    frame_cnt
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CW-1:0]    COL_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0]    ROW_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0]    COL_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0]    ROW_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0]    HS_FIRST = CW'(HS_START);
  localparam logic [CW-1:0]    HS_LAST  = CW'(HS_START + H_SYNC - 1);
  localparam logic [CW-1:0]    VS_FIRST = CW'(VS_START);
  localparam logic [CW-1:0]    VS_LAST  = CW'(VS_START + V_SYNC - 1);
  localparam logic [2:0]       DLY_IDLE = {~HS_POL, ~VS_POL, 1'b1};

  // Geometry must be representable in the coordinate width.
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end
  if (((H_TOTAL - 1) >> CW) != 0 || ((V_TOTAL - 1) >> CW) != 0) begin : g_bad_cw
    $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end

  logic [DIV_W-1:0] div_q;
  logic             col_last;
  logic             row_last;

  assign pix_en    = en && (div_q == DIV_LAST);
  assign col_last  = (col == COL_LAST);
  assign row_last  = (row == ROW_LAST);
  assign line_end  = pix_en && col_last && !sync_clr;
  assign frame_end = line_end && row_last;

  // Pixel clock divider; idles at zero so a resume gets a full period.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else if (sync_clr || !en || (div_q == DIV_LAST)) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Raster position.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (sync_clr) begin
      col <= '0;
      row <= '0;
    end else if (pix_en) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + CW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (frame_end) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

  always_comb begin
    blank = (col >= COL_ACT) || (row >= ROW_ACT);
    HS    = ((col >= HS_FIRST) && (col <= HS_LAST)) ? HS_POL : ~HS_POL;
    VS    = ((row >= VS_FIRST) && (row <= VS_LAST)) ? VS_POL : ~VS_POL;
  end

  // Sync/blank delay matching the frame-buffer read latency, in pixel periods.
  if (PIPE == 0) begin : g_nodly
    assign HS_d    = HS;
    assign VS_d    = VS;
    assign blank_d = blank;
  end else begin : g_dly
    logic [2:0] dly_q [PIPE];

    always_ff @(posedge clk_50 or posedge reset) begin
      if (reset) begin
        for (int unsigned i = 0; i < PIPE; i++) dly_q[i] <= DLY_IDLE;
      end else if (sync_clr) begin
        for (int unsigned i = 0; i < PIPE; i++) dly_q[i] <= DLY_IDLE;
      end else if (pix_en) begin
        dly_q[0] <= {HS, VS, blank};
        for (int unsigned i = 1; i < PIPE; i++) dly_q[i] <= dly_q[i-1];
      end
    end

    assign {HS_d, VS_d, blank_d} = dly_q[PIPE-1];
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three geometries checked cycle-by-cycle against a
// linear-pixel-index model, plus a table of hand-derived checkpoints.
module tb_vga_timing_gen;

  localparam int unsigned CW = 10;

  localparam int S_PE = 0, S_LE = 1, S_FE = 2, S_COL = 3, S_ROW = 4, S_HS = 5;
  localparam int S_VS = 6, S_BL = 7, S_HSD = 8, S_VSD = 9, S_BLD = 10, S_FC = 11;

  typedef struct {
    int ht, ha, hs0, hs1, vt, va, vs0, vs1, dv, pp;
    bit hp, vp;
  } geo_t;

  typedef struct {
    int dv;
    int px;
    int fc;
    logic [3:0][2:0] hist;
  } mst_t;

  typedef struct packed {
    logic pe, le, fe;
    logic [CW-1:0] col, row;
    logic hs, vs, bl, hsd, vsd, bld;
    logic [7:0] fc;
  } obs_t;

  typedef struct {
    int k;
    int inst;
    int sid;
    int val;
  } vec_t;

  logic clk_50 = 1'b0;
  logic reset, en, sync_clr;
  logic [2:0] pe, le, fe, hs, vs, bl, hsd, vsd, bld;
  logic [CW-1:0] col [3];
  logic [CW-1:0] row [3];
  logic [7:0] fc [3];

  geo_t g [3];
  mst_t s [3];
  obs_t sb_q [$];
  vec_t vt [$];
  int n_tests = 0;
  int n_fail = 0;
  int n_edges = 0;
  string sname [12] = '{"pix_en", "line_end", "frame_end", "col", "row", "HS",
                        "VS", "blank", "HS_d", "VS_d", "blank_d", "frame_cnt"};

  always #5 clk_50 = ~clk_50;

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .CLK_DIV(2), .HS_POL(1'b0), .VS_POL(1'b0), .PIPE(1), .CW(CW)
  ) u_a (
    .clk_50(clk_50), .reset(reset), .en(en), .sync_clr(sync_clr),
    .pix_en(pe[0]), .col(col[0]), .row(row[0]), .HS(hs[0]), .VS(vs[0]),
    .blank(bl[0]), .HS_d(hsd[0]), .VS_d(vsd[0]), .blank_d(bld[0]),
    .line_end(le[0]), .frame_end(fe[0]), .frame_cnt(fc[0])
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1), .HS_POL(1'b1), .VS_POL(1'b1), .PIPE(0), .CW(CW)
  ) u_b (
    .clk_50(clk_50), .reset(reset), .en(en), .sync_clr(sync_clr),
    .pix_en(pe[1]), .col(col[1]), .row(row[1]), .HS(hs[1]), .VS(vs[1]),
    .blank(bl[1]), .HS_d(hsd[1]), .VS_d(vsd[1]), .blank_d(bld[1]),
    .line_end(le[1]), .frame_end(fe[1]), .frame_cnt(fc[1])
  );

  vga_timing_gen u_c (
    .clk_50(clk_50), .reset(reset), .en(en), .sync_clr(sync_clr),
    .pix_en(pe[2]), .col(col[2]), .row(row[2]), .HS(hs[2]), .VS(vs[2]),
    .blank(bl[2]), .HS_d(hsd[2]), .VS_d(vsd[2]), .blank_d(bld[2]),
    .line_end(le[2]), .frame_end(fe[2]), .frame_cnt(fc[2])
  );

  function automatic geo_t mk_geo(int ha, int hfp, int hsy, int hbp, int va, int vfp,
                                  int vsy, int vbp, int dv, bit hp, bit vp, int pp);
    geo_t r;
    r.ht = ha + hfp + hsy + hbp;  r.ha = ha;
    r.hs0 = ha + hfp;             r.hs1 = ha + hfp + hsy - 1;
    r.vt = va + vfp + vsy + vbp;  r.va = va;
    r.vs0 = va + vfp;             r.vs1 = va + vfp + vsy - 1;
    r.dv = dv; r.hp = hp; r.vp = vp; r.pp = pp;
    return r;
  endfunction

  function automatic logic [2:0] dec(geo_t gg, int px);
    int c, r;
    logic h, v, b;
    c = px % gg.ht;
    r = px / gg.ht;
    h = (c >= gg.hs0 && c <= gg.hs1) ? gg.hp : ~gg.hp;
    v = (r >= gg.vs0 && r <= gg.vs1) ? gg.vp : ~gg.vp;
    b = (c >= gg.ha) || (r >= gg.va);
    return {h, v, b};
  endfunction

  function automatic logic [2:0] idle(geo_t gg);
    return {~gg.hp, ~gg.vp, 1'b1};
  endfunction

  function automatic mst_t m_reset(geo_t gg);
    mst_t r;
    r.dv = 0; r.px = 0; r.fc = 0;
    for (int k = 0; k < 4; k++) r.hist[k] = idle(gg);
    return r;
  endfunction

  function automatic obs_t m_pred(geo_t gg, mst_t st, bit e, bit clr);
    obs_t o;
    logic [2:0] d, dl;
    o.pe  = e && (st.dv == gg.dv - 1);
    o.le  = o.pe && !clr && (st.px % gg.ht == gg.ht - 1);
    o.fe  = o.le && (st.px == gg.ht * gg.vt - 1);
    o.col = CW'(st.px % gg.ht);
    o.row = CW'(st.px / gg.ht);
    d  = dec(gg, st.px);
    dl = (gg.pp == 0) ? d : st.hist[gg.pp - 1];
    {o.hs, o.vs, o.bl}    = d;
    {o.hsd, o.vsd, o.bld} = dl;
    o.fc = 8'(st.fc);
    return o;
  endfunction

  function automatic mst_t m_step(geo_t gg, mst_t st, bit e, bit clr);
    mst_t n;
    n = st;
    if (clr) begin
      n.dv = 0;
      n.px = 0;
      for (int k = 0; k < 4; k++) n.hist[k] = idle(gg);
    end else if (!e) begin
      n.dv = 0;
    end else if (st.dv == gg.dv - 1) begin
      n.dv = 0;
      if (st.px == gg.ht * gg.vt - 1) n.fc = (st.fc + 1) % 256;
      n.hist = {st.hist[2:0], dec(gg, st.px)};
      n.px = (st.px + 1) % (gg.ht * gg.vt);
    end else begin
      n.dv = st.dv + 1;
    end
    return n;
  endfunction

  function automatic obs_t get_obs(int i);
    obs_t o;
    o.pe = pe[i]; o.le = le[i]; o.fe = fe[i];
    o.col = col[i]; o.row = row[i];
    o.hs = hs[i]; o.vs = vs[i]; o.bl = bl[i];
    o.hsd = hsd[i]; o.vsd = vsd[i]; o.bld = bld[i];
    o.fc = fc[i];
    return o;
  endfunction

  function automatic int sig(int i, int k);
    obs_t o;
    int r;
    o = get_obs(i);
    r = -1;
    case (k)
      S_PE:  r = int'(o.pe);
      S_LE:  r = int'(o.le);
      S_FE:  r = int'(o.fe);
      S_COL: r = int'(o.col);
      S_ROW: r = int'(o.row);
      S_HS:  r = int'(o.hs);
      S_VS:  r = int'(o.vs);
      S_BL:  r = int'(o.bl);
      S_HSD: r = int'(o.hsd);
      S_VSD: r = int'(o.vsd);
      S_BLD: r = int'(o.bld);
      S_FC:  r = int'(o.fc);
      default: r = -1;
    endcase
    return r;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_sig(int i, int sid, int val, string tag);
    chk($sformatf("%s u%0d.%s", tag, i, sname[sid]), sig(i, sid), val);
  endtask

  task automatic add(int k, int inst, int sid, int val);
    vec_t v;
    v.k = k; v.inst = inst; v.sid = sid; v.val = val;
    vt.push_back(v);
  endtask

  // Drive inputs and queue what each instance should show this cycle.
  task automatic drive(bit e, bit clr);
    en = e;
    sync_clr = clr;
    for (int i = 0; i < 3; i++) sb_q.push_back(m_pred(g[i], s[i], e, clr));
  endtask

  task automatic check_sb();
    obs_t exp, act;
    #1;
    for (int i = 0; i < 3; i++) begin
      exp = sb_q.pop_front();
      act = get_obs(i);
      n_tests++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL scoreboard u%0d edge %0d: got %h, expected %h", i, n_edges, act, exp);
      end
    end
  endtask

  task automatic cyc(bit e, bit clr);
    drive(e, clr);
    check_sb();
    @(posedge clk_50);
    for (int i = 0; i < 3; i++) s[i] = m_step(g[i], s[i], e, clr);
    n_edges++;
    @(negedge clk_50);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int fc_a;

    reset = 1'b1; en = 1'b0; sync_clr = 1'b0;
    g[0] = mk_geo(16, 4, 6, 6, 10, 2, 2, 3, 2, 1'b0, 1'b0, 1);
    g[1] = mk_geo(8, 2, 3, 3, 4, 1, 1, 1, 1, 1'b1, 1'b1, 0);
    g[2] = mk_geo(640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0, 1'b0, 2);
    for (int i = 0; i < 3; i++) s[i] = m_reset(g[i]);

    // Checkpoints: {edges since reset release, instance, signal, value}
    add(0, 1, S_COL, 0);   add(0, 1, S_ROW, 0);   add(0, 1, S_HS, 0);
    add(0, 1, S_BL, 0);    add(0, 1, S_LE, 0);    add(3, 1, S_PE, 1);
    add(7, 1, S_COL, 7);   add(7, 1, S_BL, 0);    add(8, 1, S_COL, 8);
    add(8, 1, S_BL, 1);    add(9, 1, S_HS, 0);    add(10, 1, S_HS, 1);
    add(12, 1, S_HS, 1);   add(13, 1, S_HS, 0);   add(15, 1, S_COL, 15);
    add(15, 1, S_LE, 1);   add(16, 1, S_COL, 0);  add(16, 1, S_ROW, 1);
    add(16, 1, S_LE, 0);   add(16, 1, S_BL, 0);
    add(32, 0, S_COL, 16); add(32, 0, S_BL, 1);   add(32, 0, S_BLD, 0);
    add(34, 0, S_COL, 17); add(34, 0, S_BLD, 1);  add(38, 0, S_HS, 1);
    add(40, 0, S_COL, 20); add(40, 0, S_HS, 0);   add(50, 0, S_HS, 0);
    add(52, 0, S_HS, 1);
    add(79, 1, S_COL, 15); add(79, 1, S_ROW, 4);  add(79, 1, S_LE, 1);
    add(79, 1, S_VS, 0);   add(80, 1, S_ROW, 5);  add(80, 1, S_VS, 1);
    add(80, 1, S_BL, 1);   add(95, 1, S_VS, 1);   add(95, 1, S_LE, 1);
    add(96, 1, S_ROW, 6);  add(96, 1, S_VS, 0);   add(111, 1, S_FE, 1);
    add(112, 1, S_COL, 0); add(112, 1, S_ROW, 0); add(112, 1, S_FC, 1);
    add(112, 1, S_BL, 0);
    add(766, 0, S_ROW, 11); add(766, 0, S_VS, 1); add(768, 0, S_ROW, 12);
    add(768, 0, S_VS, 0);   add(832, 0, S_VS, 0); add(896, 0, S_VS, 1);
    add(1086, 0, S_FE, 0);  add(1087, 0, S_FE, 1); add(1087, 0, S_LE, 1);
    add(1088, 0, S_COL, 0); add(1088, 0, S_ROW, 0); add(1088, 0, S_FC, 1);
    add(1278, 2, S_COL, 639); add(1278, 2, S_BL, 0); add(1280, 2, S_COL, 640);
    add(1280, 2, S_BL, 1);  add(1280, 2, S_BLD, 0); add(1282, 2, S_BLD, 0);
    add(1284, 2, S_COL, 642); add(1284, 2, S_BLD, 1); add(1310, 2, S_HS, 1);
    add(1312, 2, S_COL, 656); add(1312, 2, S_HS, 0); add(1314, 2, S_HSD, 1);
    add(1316, 2, S_HSD, 0); add(1502, 2, S_COL, 751); add(1502, 2, S_HS, 0);
    add(1504, 2, S_HS, 1);  add(1598, 2, S_COL, 799); add(1598, 2, S_LE, 0);
    add(1599, 2, S_LE, 1);  add(1600, 2, S_COL, 0); add(1600, 2, S_ROW, 1);

    // Reset state.
    @(negedge clk_50);
    @(negedge clk_50);
    drive(1'b0, 1'b0);
    check_sb();
    chk_sig(0, S_PE, 0, "reset");  chk_sig(0, S_HS, 1, "reset");
    chk_sig(0, S_VS, 1, "reset");  chk_sig(0, S_BL, 0, "reset");
    chk_sig(0, S_BLD, 1, "reset"); chk_sig(0, S_HSD, 1, "reset");
    chk_sig(0, S_FC, 0, "reset");  chk_sig(1, S_HS, 0, "reset");
    chk_sig(2, S_BLD, 1, "reset"); chk_sig(2, S_VSD, 1, "reset");

    @(negedge clk_50);
    reset = 1'b0;
    en = 1'b1;
    n_edges = 0;

    foreach (vt[j]) begin
      guard = 0;
      while (n_edges < vt[j].k && guard < 20000) begin
        cyc(1'b1, 1'b0);
        guard++;
      end
      chk_sig(vt[j].inst, vt[j].sid, vt[j].val, $sformatf("edge%0d", vt[j].k));
    end

    // Freeze u_c at col 100, row 5 for 37 clocks, then resume.
    guard = 0;
    while (n_edges < 8200 && guard < 20000) begin
      cyc(1'b1, 1'b0);
      guard++;
    end
    chk_sig(2, S_COL, 100, "pre-hold"); chk_sig(2, S_ROW, 5, "pre-hold");
    chk_sig(0, S_FC, 7, "pre-hold");    chk_sig(1, S_FC, 73, "pre-hold");
    for (int k = 0; k < 37; k++) cyc(1'b0, 1'b0);
    chk_sig(2, S_COL, 100, "hold"); chk_sig(2, S_ROW, 5, "hold");
    chk_sig(2, S_PE, 0, "hold");    chk_sig(0, S_FC, 7, "hold");
    cyc(1'b1, 1'b0);
    chk_sig(2, S_PE, 1, "resume+1"); chk_sig(2, S_COL, 100, "resume+1");
    cyc(1'b1, 1'b0);
    chk_sig(2, S_COL, 101, "resume+2");

    // sync_clr on u_a's final pixel, coincident with pix_en.
    guard = 0;
    while (!(s[0].px == 543 && s[0].dv == 1) && guard < 2000) begin
      cyc(1'b1, 1'b0);
      guard++;
    end
    chk("sync_clr position reached", int'(guard < 2000), 1);
    fc_a = s[0].fc;
    en = 1'b1;
    sync_clr = 1'b1;
    #1;
    chk_sig(0, S_PE, 1, "clr");
    chk_sig(0, S_FE, 0, "clr");
    chk_sig(0, S_LE, 0, "clr");
    cyc(1'b1, 1'b1);
    chk_sig(0, S_COL, 0, "post-clr"); chk_sig(0, S_ROW, 0, "post-clr");
    chk_sig(0, S_FC, fc_a, "post-clr"); chk_sig(0, S_BLD, 1, "post-clr");
    for (int k = 0; k < 100; k++) cyc(1'b1, 1'b0);

    // Asynchronous reset mid-frame.
    guard = 0;
    while (s[0].px < 8 * 32 && guard < 2000) begin
      cyc(1'b1, 1'b0);
      guard++;
    end
    chk_sig(0, S_ROW, 8, "pre-reset");
    #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) s[i] = m_reset(g[i]);
    chk_sig(0, S_COL, 0, "async-reset"); chk_sig(0, S_ROW, 0, "async-reset");
    chk_sig(0, S_FC, 0, "async-reset");  chk_sig(0, S_BLD, 1, "async-reset");
    chk_sig(2, S_FC, 0, "async-reset");  chk_sig(2, S_HSD, 1, "async-reset");
    @(posedge clk_50);
    @(negedge clk_50);
    reset = 1'b0;
    for (int k = 0; k < 200; k++) cyc(1'b1, 1'b0);
    chk_sig(0, S_COL, 4, "after-reset"); chk_sig(0, S_ROW, 3, "after-reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
